// File: rtl/special_alu_arbiter.sv
// special_alu_arbiter
// Shares one special_alu between NUM_REQ requesters. Requests are granted
// round-robin, one ALU transaction is in flight at a time (operand channel,
// then result channel), and the 11-bit result is routed back to the granted
// requester. A watchdog turns a missing ALU result into an error response.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_valid/ready           per-requester request handshake (ready one-hot)
//   req_operand/operation     packed 8-bit operand / 3-bit op per requester
//   rsp_valid/ready           per-requester response handshake (valid one-hot)
//   rsp_result, rsp_error     response payload (error = watchdog timeout)
//   alu_a_*                   operand channel to the ALU
//   alu_b_*                   result channel from the ALU
//   busy, grant_id            status: not idle / current or last grant
//   stat_timeouts             saturating count of watchdog timeouts
module special_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_operand,
    input  logic [3*NUM_REQ-1:0]   req_operation,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [10:0]            rsp_result,
    output logic                   rsp_error,
    output logic                   alu_a_valid,
    input  logic                   alu_a_ready,
    output logic [7:0]             alu_a_operand,
    output logic [2:0]             alu_b_operation,
    input  logic                   alu_b_valid,
    output logic                   alu_b_ready,
    input  logic [10:0]            alu_b_result,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [7:0]             stat_timeouts
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    logic [2:0]         r_last;
    logic [2:0]         r_gid;
    logic [7:0]         r_operand;
    logic [2:0]         r_op;
    logic [10:0]        r_result;
    logic               r_error;
    logic [7:0]         r_timeouts;
    logic [15:0]        r_wdog;
    logic               r_b_ready;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [3:0]           w_sum;
    logic                 w_found;
    logic [2:0]           w_win;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [NUM_REQ-1:0]   w_gid_oh;

    // Round-robin pick: rotate the doubled request vector so bit 0 is the
    // requester right after r_last, then take the first set bit.
    always_comb begin
        w_dbl   = {req_valid, req_valid} >> ({1'b0, r_last} + 4'd1);
        w_found = 1'b0;
        w_sum   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_dbl[j]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_last} + 4'(j) + 4'd1;
            end
        end
        w_win = (w_sum >= 4'(NUM_REQ)) ? 3'(w_sum - 4'(NUM_REQ)) : w_sum[2:0];
    end

    assign w_win_oh = NUM_REQ'(1) << w_win;
    assign w_gid_oh = NUM_REQ'(1) << r_gid;

    // Grant is combinational in IDLE; masked during reset so nothing is
    // offered while the block is being cleared.
    assign req_ready       = (r_state == S_IDLE && w_found && !rst) ? w_win_oh : '0;
    assign rsp_valid       = (r_state == S_RESP) ? w_gid_oh : '0;
    assign alu_a_valid     = (r_state == S_ISSUE);
    assign busy            = (r_state != S_IDLE);
    assign alu_a_operand   = r_operand;
    assign alu_b_operation = r_op;
    assign rsp_result      = r_result;
    assign rsp_error       = r_error;
    assign grant_id        = r_gid;
    assign stat_timeouts   = r_timeouts;
    assign alu_b_ready     = r_b_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last     <= 3'(NUM_REQ - 1);
            r_gid      <= '0;
            r_operand  <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_error    <= 1'b0;
            r_timeouts <= '0;
            r_wdog     <= '0;
            r_b_ready  <= 1'b0;
        end else begin
            // Always accept results; anything outside WAIT (a late answer
            // after a timeout or reset) is simply dropped.
            r_b_ready <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_operand <= req_operand[8*w_win +: 8];
                        r_op      <= req_operation[3*w_win +: 3];
                        r_gid     <= w_win;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (alu_a_ready) begin
                        r_wdog  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (alu_b_valid) begin
                        r_result <= alu_b_result;
                        r_error  <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (r_wdog == 16'(TIMEOUT - 1)) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                        if (r_timeouts != 8'hFF)
                            r_timeouts <= r_timeouts + 8'd1;
                        r_state  <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                S_RESP: begin
                    if (|(rsp_ready & w_gid_oh)) begin
                        r_last  <= r_gid;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/special_alu_arbiter.md
Name: special_alu_arbiter

Overview:
- Shares one special_alu instance between NUM_REQ independent requesters.
- Accepts operand+operation requests, grants round-robin, sequences one ALU transaction at a time (operand channel, then result channel), and routes the 11-bit result back to the granted requester.
- Includes a result watchdog that returns an error response if the ALU never answers.
- Sits between the requester components and special_alu.

Parameters:
- NUM_REQ, 4, number of requesters (legal 2..8)
- TIMEOUT, 255, cycles in WAIT_RES before an error response (legal 1..65535)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
- req_operand  in  8*NUM_REQ  operand, requester i at bits [8i+7:8i]
- req_operation  in  3*NUM_REQ  operation code, requester i at bits [3i+2:3i]
- rsp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_result  out  11  result for the active response
- rsp_error  out  1  1 = watchdog timeout, rsp_result forced 0
- alu_a_valid  out  1  operand valid to ALU
- alu_a_ready  in  1  ALU operand accept
- alu_a_operand  out  8  latched operand
- alu_b_operation  out  3  latched operation, held stable ISSUE..WAIT_RES
- alu_b_valid  in  1  ALU result valid
- alu_b_ready  out  1  result accept
- alu_b_result  in  11  ALU result
- busy  out  1  state != IDLE
- grant_id  out  3  index of current/last granted requester
- stat_timeouts  out  8  saturating timeout count

Behaviour:
- Reset (rst high, asynchronous):
  - state=IDLE, rr pointer last=NUM_REQ-1, so requester 0 has top priority.
  - req_ready=0, rsp_valid=0, alu_a_valid=0, alu_b_ready=0.
  - alu_a_operand=0, alu_b_operation=0, rsp_result=0, rsp_error=0, grant_id=0, busy=0, stat_timeouts=0, watchdog=0.
- alu_b_ready: register set to 1 on the first clk after rst deasserts, then held 1.
  - Results arriving outside WAIT_RES (stale post-timeout results) are accepted and discarded.
- IDLE:
  - Winner w = first i with req_valid[i], scanning last+1, last+2, ... modulo NUM_REQ.
  - req_ready[w]=1 combinationally in the same cycle.
  - On that edge: latch operand/operation/w, grant_id<=w, go ISSUE.
  - No valid request: stay IDLE, req_ready=0.
- ISSUE:
  - alu_a_valid=1. Operand and operation are driven from registers.
  - On alu_a_valid&&alu_a_ready: watchdog<=0, go WAIT_RES.
  - No timeout applies in ISSUE.
- WAIT_RES:
  - On alu_b_valid: rsp_result<=alu_b_result, rsp_error<=0, go RESPOND.
  - Otherwise watchdog++. When watchdog==TIMEOUT-1 with no result: rsp_result<=0, rsp_error<=1, stat_timeouts++ (saturating at 255), go RESPOND.
  - Result valid in the same cycle as the timeout: the result wins, no error.
- RESPOND:
  - rsp_valid[grant_id]=1; rsp_result/rsp_error held.
  - On rsp_ready[grant_id]: last<=grant_id, rsp_valid drops, go IDLE.
  - rsp_ready of other requesters is ignored.
- Timing:
  - Minimum request-to-response latency: 3 cycles (IDLE accept, ISSUE with alu_a_ready=1, WAIT_RES result same cycle, rsp_valid on the following cycle).
  - Next accept is no earlier than the cycle after the response handshake; there is no overlap.
- Only one transaction is ever outstanding. req_ready and rsp_valid are never asserted in the same cycle.
- req_valid deasserted by a requester before grant: no effect; no latching occurs without req_ready.
- Reset mid-operation: immediate return to reset values; the in-flight ALU result is later drained and discarded via alu_b_ready.

Test Plan:
- Single request: req0 operand 8'h05, op 3'd1; ALU ready immediately, returns 11'h00A after 2 cycles -> req_ready[0] one cycle, alu_a_operand=05/op=1, rsp_valid[0] with rsp_result=11'h00A, rsp_error=0.
- Simultaneous: all four req_valid held from reset -> grant order 0,1,2,3,0. Each operand (8'h10+i) appears on alu_a_operand in that order.
- Fairness: after req2 is served, only req1 and req3 are valid -> req3 granted before req1.
- Watchdog: TIMEOUT=8, ALU never asserts alu_b_valid -> rsp_valid after 8 WAIT_RES cycles, rsp_error=1, rsp_result=0, stat_timeouts=1. A late alu_b_valid in IDLE is drained and not forwarded.
- Backpressure: alu_a_ready low for 5 cycles, then rsp_ready[1] low for 4 cycles -> operand/operation and rsp_result stable throughout, single handshake each, no new grant until rsp_ready[1].
- Reset mid-op: rst pulsed during WAIT_RES -> all outputs at reset values. The next request is served normally with the correct result.
